// File: rtl/fitness_eval_ctrl_if.sv
// Memory, evaluator and fitness write-back bundle seen by fitness_eval_ctrl.
// master = controller side, slave = memories/evaluator side.
interface fitness_eval_ctrl_if #(
    parameter int unsigned DATA_WIDTH        = 4,
    parameter int unsigned INDIVIDUAL_LENGTH = 22,
    parameter int unsigned SELF_FIT_LENGTH   = 10,
    parameter int unsigned IDX_WIDTH         = 8,
    parameter int unsigned CFG_ADDR_WIDTH    = 4
);
    logic                         cfg_rd_en_o;
    logic [CFG_ADDR_WIDTH-1:0]    cfg_rd_addr_o;
    logic [DATA_WIDTH-1:0]        cfg_rd_data_i;

    logic                         pop_rd_en_o;
    logic [IDX_WIDTH-1:0]         pop_rd_addr_o;
    logic [INDIVIDUAL_LENGTH-1:0] pop_rd_data_i;

    logic [DATA_WIDTH-1:0]        self_energy_o;
    logic [DATA_WIDTH-1:0]        interact_energy_o;
    logic                         wr_self_valid_o;
    logic                         wr_interact_valid_o;
    logic                         eval_valid_o;
    logic [IDX_WIDTH-1:0]         eval_idx_o;
    logic [INDIVIDUAL_LENGTH-1:0] eval_vec_o;

    logic                         eval_out_valid_i;
    logic [SELF_FIT_LENGTH-1:0]   eval_energy_i;
    logic [IDX_WIDTH-1:0]         eval_wb_idx_i;

    logic                         fit_wr_en_o;
    logic [IDX_WIDTH-1:0]         fit_wr_addr_o;
    logic [SELF_FIT_LENGTH-1:0]   fit_wr_data_o;

    modport master (
        output cfg_rd_en_o, cfg_rd_addr_o,
        input  cfg_rd_data_i,
        output pop_rd_en_o, pop_rd_addr_o,
        input  pop_rd_data_i,
        output self_energy_o, interact_energy_o, wr_self_valid_o, wr_interact_valid_o,
        output eval_valid_o, eval_idx_o, eval_vec_o,
        input  eval_out_valid_i, eval_energy_i, eval_wb_idx_i,
        output fit_wr_en_o, fit_wr_addr_o, fit_wr_data_o
    );

    modport slave (
        input  cfg_rd_en_o, cfg_rd_addr_o,
        output cfg_rd_data_i,
        input  pop_rd_en_o, pop_rd_addr_o,
        output pop_rd_data_i,
        input  self_energy_o, interact_energy_o, wr_self_valid_o, wr_interact_valid_o,
        input  eval_valid_o, eval_idx_o, eval_vec_o,
        output eval_out_valid_i, eval_energy_i, eval_wb_idx_i,
        input  fit_wr_en_o, fit_wr_addr_o, fit_wr_data_o
    );
endinterface

// File: rtl/fitness_eval_ctrl.sv
// Pass sequencer for the pipelined fitness evaluator: config load, population stream, write-back.
// Optional FITNESS_CTRL_BEST_TRACK_EN adds per-pass minimum-energy tracking (best_energy_o/best_idx_o).
module fitness_eval_ctrl #(
    parameter int unsigned NUM_PARTICLE_TYPE = 3,
    parameter int unsigned DATA_WIDTH        = 4,
    parameter int unsigned INDIVIDUAL_LENGTH = 22,
    parameter int unsigned SELF_FIT_LENGTH   = 10,
    parameter int unsigned POP_SIZE          = 50,
    parameter int unsigned IDX_WIDTH         = 8,
    parameter int unsigned CFG_ADDR_WIDTH    = 4
) (
    input  logic                       clk_i,
    input  logic                       rst_n,
    input  logic                       start_i,
    input  logic                       cfg_loaded_skip_i,
    output logic                       busy_o,
    output logic                       done_o,
`ifdef FITNESS_CTRL_BEST_TRACK_EN
    output logic [SELF_FIT_LENGTH-1:0] best_energy_o,
    output logic [IDX_WIDTH-1:0]       best_idx_o,
`endif
    fitness_eval_ctrl_if.master        bus
);

    localparam int unsigned N_SELF  = NUM_PARTICLE_TYPE;
    localparam int unsigned N_IE    = NUM_PARTICLE_TYPE * NUM_PARTICLE_TYPE;
    localparam int unsigned CNT_MAX = (N_IE > POP_SIZE) ? N_IE : POP_SIZE;
    localparam int unsigned CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
    localparam int unsigned WB_W    = $clog2(POP_SIZE + 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD_SE,
        S_LOAD_IE,
        S_STREAM,
        S_DRAIN,
        S_DONE
    } state_e;

    state_e                    state_q, state_d;
    logic [CNT_W-1:0]          cnt_q, cnt_d;
    logic [WB_W-1:0]           wb_cnt_q, wb_cnt_d;
    logic [WB_W-1:0]           wb_cnt_inc;
    logic                      wb_beat;
    logic                      cfg_valid_q;
    logic                      ie_last_q;

    logic                      busy_d;
    logic                      done_d;
    logic                      cfg_rd_en_d;
    logic [CFG_ADDR_WIDTH-1:0] cfg_rd_addr_d;
    logic                      pop_rd_en_d;
    logic [IDX_WIDTH-1:0]      pop_rd_addr_d;

    // Only beats that belong to the running pass advance the write-back count.
    assign wb_beat    = bus.eval_out_valid_i && (state_q == S_STREAM || state_q == S_DRAIN);
    assign wb_cnt_inc = wb_cnt_q + WB_W'(wb_beat);

    // Next state, phase counter and the read strobes/addresses for the coming cycle.
    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        wb_cnt_d      = wb_cnt_inc;
        busy_d        = 1'b0;
        done_d        = 1'b0;
        cfg_rd_en_d   = 1'b0;
        cfg_rd_addr_d = '0;
        pop_rd_en_d   = 1'b0;
        pop_rd_addr_d = '0;

        case (state_q)
            S_IDLE: begin
                wb_cnt_d = '0;
                if (start_i) begin
                    cnt_d   = '0;
                    state_d = (cfg_loaded_skip_i && cfg_valid_q) ? S_STREAM : S_LOAD_SE;
                end
            end
            S_LOAD_SE: begin
                if (cnt_q == CNT_W'(N_SELF - 1)) begin
                    cnt_d   = '0;
                    state_d = S_LOAD_IE;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            S_LOAD_IE: begin
                if (cnt_q == CNT_W'(N_IE - 1)) begin
                    cnt_d   = '0;
                    state_d = S_STREAM;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            S_STREAM: begin
                if (cnt_q == CNT_W'(POP_SIZE - 1)) begin
                    cnt_d   = '0;
                    state_d = S_DRAIN;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            S_DRAIN: begin
                if (wb_cnt_inc >= WB_W'(POP_SIZE)) begin
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                wb_cnt_d = '0;
                state_d  = S_IDLE;
            end
            default: begin
                wb_cnt_d = '0;
                state_d  = S_IDLE;
            end
        endcase

        busy_d = (state_d != S_IDLE);
        done_d = (state_d == S_DONE);

        if (state_d == S_LOAD_SE) begin
            cfg_rd_en_d   = 1'b1;
            cfg_rd_addr_d = CFG_ADDR_WIDTH'(cnt_d);
        end else if (state_d == S_LOAD_IE) begin
            cfg_rd_en_d   = 1'b1;
            cfg_rd_addr_d = CFG_ADDR_WIDTH'(N_SELF) + CFG_ADDR_WIDTH'(cnt_d);
        end

        if (state_d == S_STREAM) begin
            pop_rd_en_d   = 1'b1;
            pop_rd_addr_d = IDX_WIDTH'(cnt_d);
        end
    end

    // State register and registered control outputs.
    always_ff @(posedge clk_i or negedge rst_n) begin
        if (!rst_n) begin
            state_q           <= S_IDLE;
            cnt_q             <= '0;
            wb_cnt_q          <= '0;
            busy_o            <= 1'b0;
            done_o            <= 1'b0;
            bus.cfg_rd_en_o   <= 1'b0;
            bus.cfg_rd_addr_o <= '0;
            bus.pop_rd_en_o   <= 1'b0;
            bus.pop_rd_addr_o <= '0;
        end else begin
            state_q           <= state_d;
            cnt_q             <= cnt_d;
            wb_cnt_q          <= wb_cnt_d;
            busy_o            <= busy_d;
            done_o            <= done_d;
            bus.cfg_rd_en_o   <= cfg_rd_en_d;
            bus.cfg_rd_addr_o <= cfg_rd_addr_d;
            bus.pop_rd_en_o   <= pop_rd_en_d;
            bus.pop_rd_addr_o <= pop_rd_addr_d;
        end
    end

    // Evaluator strobes trail the read that was issued one cycle earlier; state_q names its phase.
    always_ff @(posedge clk_i or negedge rst_n) begin
        if (!rst_n) begin
            bus.wr_self_valid_o     <= 1'b0;
            bus.wr_interact_valid_o <= 1'b0;
            bus.eval_valid_o        <= 1'b0;
            bus.eval_idx_o          <= '0;
            ie_last_q               <= 1'b0;
            cfg_valid_q             <= 1'b0;
        end else begin
            bus.wr_self_valid_o     <= (state_q == S_LOAD_SE);
            bus.wr_interact_valid_o <= (state_q == S_LOAD_IE);
            bus.eval_valid_o        <= (state_q == S_STREAM);
            bus.eval_idx_o          <= (state_q == S_STREAM) ? bus.pop_rd_addr_o : '0;
            ie_last_q               <= (state_q == S_LOAD_IE) && (cnt_q == CNT_W'(N_IE - 1));
            if (bus.wr_interact_valid_o && ie_last_q) begin
                cfg_valid_q <= 1'b1;
            end
        end
    end

    // Read data only exists in the cycle after the strobe, so it passes straight through, gated.
    assign bus.self_energy_o     = bus.wr_self_valid_o     ? bus.cfg_rd_data_i : '0;
    assign bus.interact_energy_o = bus.wr_interact_valid_o ? bus.cfg_rd_data_i : '0;
    assign bus.eval_vec_o        = bus.eval_valid_o        ? bus.pop_rd_data_i : '0;

    // Fitness write-back: every evaluator result is written, counted or not.
    always_ff @(posedge clk_i or negedge rst_n) begin
        if (!rst_n) begin
            bus.fit_wr_en_o   <= 1'b0;
            bus.fit_wr_addr_o <= '0;
            bus.fit_wr_data_o <= '0;
        end else begin
            bus.fit_wr_en_o   <= bus.eval_out_valid_i;
            bus.fit_wr_addr_o <= bus.eval_wb_idx_i;
            bus.fit_wr_data_o <= bus.eval_energy_i;
        end
    end

`ifdef FITNESS_CTRL_BEST_TRACK_EN
    // Strict less-than keeps the first result on ties.
    always_ff @(posedge clk_i or negedge rst_n) begin
        if (!rst_n) begin
            best_energy_o <= '0;
            best_idx_o    <= '0;
        end else if (state_q == S_IDLE && start_i) begin
            best_energy_o <= '1;
            best_idx_o    <= '0;
        end else if (wb_beat && (bus.eval_energy_i < best_energy_o)) begin
            best_energy_o <= bus.eval_energy_i;
            best_idx_o    <= bus.eval_wb_idx_i;
        end
    end
`endif

endmodule

// File: tb/tb_fitness_eval_ctrl.sv
// Scoreboard bench for fitness_eval_ctrl: memory and latency-4 evaluator models, queued expectations.
module tb_fitness_eval_ctrl;

    localparam int unsigned N    = 3;
    localparam int unsigned DW   = 4;
    localparam int unsigned IL   = 22;
    localparam int unsigned SW   = 10;
    localparam int unsigned POP  = 50;
    localparam int unsigned IW   = 8;
    localparam int unsigned CAW  = 4;
    localparam int unsigned NCFG = N + N * N;

    logic clk_i = 1'b0;
    logic rst_n = 1'b0;
    logic start_i = 1'b0;
    logic cfg_loaded_skip_i = 1'b0;
    logic busy_o, done_o;
`ifdef FITNESS_CTRL_BEST_TRACK_EN
    logic [SW-1:0] best_energy_o;
    logic [IW-1:0] best_idx_o;
`endif

    fitness_eval_ctrl_if #(.DATA_WIDTH(DW), .INDIVIDUAL_LENGTH(IL), .SELF_FIT_LENGTH(SW),
                           .IDX_WIDTH(IW), .CFG_ADDR_WIDTH(CAW)) bus ();

    fitness_eval_ctrl #(
        .NUM_PARTICLE_TYPE(N), .DATA_WIDTH(DW), .INDIVIDUAL_LENGTH(IL), .SELF_FIT_LENGTH(SW),
        .POP_SIZE(POP), .IDX_WIDTH(IW), .CFG_ADDR_WIDTH(CAW)
    ) dut (
        .clk_i(clk_i),
        .rst_n(rst_n),
        .start_i(start_i),
        .cfg_loaded_skip_i(cfg_loaded_skip_i),
        .busy_o(busy_o),
        .done_o(done_o),
`ifdef FITNESS_CTRL_BEST_TRACK_EN
        .best_energy_o(best_energy_o),
        .best_idx_o(best_idx_o),
`endif
        .bus(bus)
    );

    always #5 clk_i = ~clk_i;

    // Memories with one-cycle read latency
    logic [DW-1:0] cfg_mem    [16];
    logic [IL-1:0] pop_mem    [256];
    logic [SW-1:0] energy_tbl [256];

    always @(posedge clk_i) begin
        if (bus.cfg_rd_en_o) bus.cfg_rd_data_i <= cfg_mem[bus.cfg_rd_addr_o];
        if (bus.pop_rd_en_o) bus.pop_rd_data_i <= pop_mem[bus.pop_rd_addr_o];
    end

    // Evaluator: fixed latency 4, energy looked up per index
    logic [3:0]    ev_v = '0;
    logic [IW-1:0] ev_idx [4];
    logic [SW-1:0] ev_e   [4];
    logic          stray_v = 1'b0;
    logic [IW-1:0] stray_idx = '0;
    logic [SW-1:0] stray_e = '0;

    always @(posedge clk_i) begin
        ev_v      <= {ev_v[2:0], bus.eval_valid_o};
        ev_idx[0] <= bus.eval_idx_o;
        ev_e[0]   <= energy_tbl[bus.eval_idx_o];
        for (int j = 1; j < 4; j++) begin
            ev_idx[j] <= ev_idx[j-1];
            ev_e[j]   <= ev_e[j-1];
        end
    end

    assign bus.eval_out_valid_i = ev_v[3] | stray_v;
    assign bus.eval_wb_idx_i    = stray_v ? stray_idx : ev_idx[3];
    assign bus.eval_energy_i    = stray_v ? stray_e : ev_e[3];

    typedef struct packed { logic ie; logic [DW-1:0] d; } cfg_exp_t;
    typedef struct packed { logic [IW-1:0] idx; logic [IL-1:0] vec; } ev_exp_t;
    typedef struct packed { logic [IW-1:0] a; logic [SW-1:0] d; } wr_exp_t;

    cfg_exp_t q_cfg[$];
    ev_exp_t  q_ev[$];
    wr_exp_t  q_wr[$];

    int total = 0;
    int bad = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h want 0x%0h", name, act, exp);
        end
    endtask

    task automatic missing(input string name);
        total++;
        bad++;
        $display("FAIL %s: DUT beat with no expected entry", name);
    endtask

    task automatic step();
        @(posedge clk_i);
        #1;
    endtask

    task automatic check_all_zero(input string name);
        check({name, "_ctl"}, {busy_o, done_o, bus.cfg_rd_en_o, bus.cfg_rd_addr_o,
                               bus.pop_rd_en_o, bus.pop_rd_addr_o}, 64'd0);
        check({name, "_eval"}, {bus.wr_self_valid_o, bus.wr_interact_valid_o, bus.self_energy_o,
                                bus.interact_energy_o, bus.eval_valid_o, bus.eval_idx_o,
                                bus.eval_vec_o}, 64'd0);
        check({name, "_fit"}, {bus.fit_wr_en_o, bus.fit_wr_addr_o, bus.fit_wr_data_o}, 64'd0);
    endtask

    // Monitor: pops expectations whenever the DUT presents a beat
    int   cyc = 0;
    bit   sb_on = 1'b0;
    int   n_cfg_rd = 0, n_pop_rd = 0, n_done = 0;
    int   last_beat_cyc = 0, done_cyc = 0, cfg_rise_cyc = 0, pop_rise_cyc = 0;
    logic prev_cfg = 1'b0, prev_pop = 1'b0;

    always @(posedge clk_i) cyc <= cyc + 1;

    always @(negedge clk_i) begin
        int nstb;
        cfg_exp_t ce;
        ev_exp_t  ee;
        wr_exp_t  we;
        nstb = int'(bus.wr_self_valid_o) + int'(bus.wr_interact_valid_o) + int'(bus.eval_valid_o);
        if (nstb != 0) check("strobe_exclusive", 64'(nstb), 64'd1);
        if (bus.cfg_rd_en_o) n_cfg_rd++;
        if (bus.pop_rd_en_o) n_pop_rd++;
        if (bus.cfg_rd_en_o && !prev_cfg) cfg_rise_cyc = cyc;
        if (bus.pop_rd_en_o && !prev_pop) pop_rise_cyc = cyc;
        prev_cfg = bus.cfg_rd_en_o;
        prev_pop = bus.pop_rd_en_o;
        if (ev_v[3]) last_beat_cyc = cyc;
        if (done_o) begin
            n_done++;
            done_cyc = cyc;
        end
        if (sb_on) begin
            if (bus.wr_self_valid_o || bus.wr_interact_valid_o) begin
                if (q_cfg.size() == 0) missing("cfg_beat");
                else begin
                    ce = q_cfg.pop_front();
                    check("cfg_beat", {bus.wr_interact_valid_o,
                          bus.wr_interact_valid_o ? bus.interact_energy_o : bus.self_energy_o}, ce);
                end
            end
            if (bus.eval_valid_o) begin
                if (q_ev.size() == 0) missing("eval_in");
                else begin
                    ee = q_ev.pop_front();
                    check("eval_in", {bus.eval_idx_o, bus.eval_vec_o}, ee);
                end
            end
            if (bus.fit_wr_en_o) begin
                if (q_wr.size() == 0) missing("fit_wr");
                else begin
                    we = q_wr.pop_front();
                    check("fit_wr", {bus.fit_wr_addr_o, bus.fit_wr_data_o}, we);
                end
            end
        end
    end

    // One evaluation pass: expectations come from the memory contents and the pass rules
    task automatic run_pass(input bit skip, input bit exp_load, input bit poke_start);
        int b_cfg, b_pop, b_done, s_cyc, t;
        logic [SW-1:0] be;
        logic [IW-1:0] bi;
        if (exp_load) begin
            for (int i = 0; i < int'(N); i++) q_cfg.push_back('{ie: 1'b0, d: cfg_mem[i]});
            for (int r = 0; r < int'(N); r++)
                for (int c = 0; c < int'(N); c++)
                    q_cfg.push_back('{ie: 1'b1, d: cfg_mem[int'(N) + r * int'(N) + c]});
        end
        for (int i = 0; i < int'(POP); i++) begin
            q_ev.push_back('{idx: IW'(i), vec: pop_mem[i]});
            q_wr.push_back('{a: IW'(i), d: energy_tbl[i]});
        end
        b_cfg = n_cfg_rd;
        b_pop = n_pop_rd;
        b_done = n_done;
        start_i = 1'b1;
        cfg_loaded_skip_i = skip;
        s_cyc = cyc;
        step();
        start_i = 1'b0;
        cfg_loaded_skip_i = 1'b0;
        if (poke_start) begin
            repeat (20) step();
            check("busy_in_stream", busy_o, 1);
            start_i = 1'b1;
            step();
            start_i = 1'b0;
        end
        t = 0;
        while (n_done == b_done && t < 600) begin
            step();
            t++;
        end
        if (n_done == b_done) begin
            total++;
            bad++;
            $display("FAIL done_timeout: got no done_o within %0d cycles", t);
        end
        repeat (8) step();
        check("done_pulses", n_done - b_done, 1);
        check("done_after_last_wb", done_cyc - last_beat_cyc, 1);
        check("pop_reads", n_pop_rd - b_pop, POP);
        check("cfg_reads", n_cfg_rd - b_cfg, exp_load ? NCFG : 0);
        if (exp_load) check("first_cfg_rd_latency", cfg_rise_cyc - s_cyc, 1);
        else          check("first_pop_rd_latency", pop_rise_cyc - s_cyc, 1);
        check("queues_drained", q_cfg.size() + q_ev.size() + q_wr.size(), 0);
        check("busy_after_pass", busy_o, 0);
        be = '1;
        bi = '0;
        for (int i = 0; i < int'(POP); i++)
            if (energy_tbl[i] < be) begin
                be = energy_tbl[i];
                bi = IW'(i);
            end
`ifdef FITNESS_CTRL_BEST_TRACK_EN
        check("best_energy", best_energy_o, be);
        check("best_idx", best_idx_o, bi);
`endif
    endtask

    initial begin
        int s_cyc;
        for (int i = 0; i < 16; i++) cfg_mem[i] = DW'(i + 1);
        for (int i = 0; i < 256; i++) begin
            pop_mem[i] = IL'($urandom);
            energy_tbl[i] = SW'(i);
        end

        repeat (3) step();
        check_all_zero("reset");
        rst_n = 1'b1;
        step();

        // Abort in the middle of the interaction load
        start_i = 1'b1;
        s_cyc = cyc;
        step();
        start_i = 1'b0;
        repeat (4) step();
        check("abort_point_cfg_rd", {bus.cfg_rd_en_o, bus.cfg_rd_addr_o}, {1'b1, 4'(N + 1)});
        check("abort_point_cycle", cyc - s_cyc, 5);
        rst_n = 1'b0;
        #1;
        check_all_zero("mid_pass_reset");
        step();
        rst_n = 1'b1;
        step();
        sb_on = 1'b1;

        // Result arriving while idle is written but belongs to no pass
        q_wr.push_back('{a: IW'(7), d: SW'(123)});
        stray_idx = IW'(7);
        stray_e = SW'(123);
        stray_v = 1'b1;
        step();
        stray_v = 1'b0;
        repeat (3) step();
        check("stray_written", q_wr.size(), 0);

        // cfg_valid was lost to reset, so a skip request still loads; start poked during STREAM
        run_pass(1'b1, 1'b1, 1'b1);

        // Config already valid: skip straight to STREAM
        for (int i = 0; i < int'(POP); i++) begin
            pop_mem[i] = IL'($urandom);
            energy_tbl[i] = SW'($urandom_range(4, 1023));
        end
        energy_tbl[0] = SW'(9);
        energy_tbl[1] = SW'(3);
        energy_tbl[2] = SW'(7);
        energy_tbl[3] = SW'(3);
        run_pass(1'b1, 1'b0, 1'b0);

        // Fresh config, explicit reload
        for (int i = 0; i < int'(NCFG); i++) cfg_mem[i] = DW'($urandom);
        for (int i = 0; i < int'(POP); i++) begin
            pop_mem[i] = IL'($urandom);
            energy_tbl[i] = SW'($urandom);
        end
        run_pass(1'b0, 1'b1, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
